// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the architectural PC, runs req/ack fetches to
// instruction memory, holds the fetched word for decode and applies redirects.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic        flush,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nxt;
  logic [31:0] r_instr_pc;
  logic [31:0] w_instr_pc_nxt;
  logic        r_instr_valid;
  logic        w_instr_valid_nxt;
  logic        r_flush;
  logic        w_flush_nxt;
  logic        r_fetch_err;
  logic        w_fetch_err_nxt;
  logic [7:0]  r_tmo_cnt;
  logic [7:0]  w_tmo_cnt_nxt;
  logic        w_tmo_hit;
  logic        w_waiting;
  logic        w_misaligned;
  logic [31:0] w_pc_plus_4;

  assign w_pc_plus_4  = r_pc + 32'd4;
  assign w_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign w_waiting    = (r_state == S_FETCH) || (r_state == S_DRAIN);

  // Next-state and datapath selection; a redirect overrides stall and consumption.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;
    w_instr_valid_nxt = r_instr_valid;
    w_flush_nxt       = 1'b0;
    if (redirect_valid) begin
      w_pc_nxt          = {redirect_pc[31:2], 2'b00};
      w_instr_valid_nxt = 1'b0;
      w_flush_nxt       = 1'b1;
      // An unacked request must be drained before the bus sees a new one.
      case (r_state)
        S_FETCH: w_state_nxt = imem_ack ? S_FETCH : S_DRAIN;
        S_VALID: w_state_nxt = S_FETCH;
        S_DRAIN: w_state_nxt = imem_ack ? S_FETCH : S_DRAIN;
        default: w_state_nxt = S_FETCH;
      endcase
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            w_instr_nxt       = imem_rdata;
            w_instr_pc_nxt    = r_pc;
            w_instr_valid_nxt = 1'b1;
            w_state_nxt       = S_VALID;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end
        S_VALID: begin
          if (!stall) begin
            w_pc_nxt          = w_pc_plus_4;
            w_instr_valid_nxt = 1'b0;
            w_state_nxt       = S_FETCH;
          end else begin
            w_state_nxt = S_VALID;
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end
        default: begin
          w_instr_valid_nxt = 1'b0;
          w_state_nxt       = S_FETCH;
        end
      endcase
    end
  end

  // Ack-wait counter: counts unacked cycles in one waiting state, saturating.
  always_comb begin
    w_tmo_cnt_nxt = r_tmo_cnt;
    w_tmo_hit     = 1'b0;
    if (imem_ack || (w_state_nxt != r_state)) begin
      w_tmo_cnt_nxt = 8'd0;
    end else if (w_waiting && (r_tmo_cnt != 8'hFF)) begin
      w_tmo_cnt_nxt = r_tmo_cnt + 8'd1;
      w_tmo_hit     = ((r_tmo_cnt + 8'd1) == TMO_LIMIT);
    end else begin
      w_tmo_cnt_nxt = r_tmo_cnt;
    end
  end

  assign w_fetch_err_nxt = r_fetch_err | w_misaligned | w_tmo_hit;

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_instr       <= 32'd0;
      r_instr_pc    <= 32'd0;
      r_instr_valid <= 1'b0;
      r_flush       <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_tmo_cnt     <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_flush       <= w_flush_nxt;
      r_fetch_err   <= w_fetch_err_nxt;
      r_tmo_cnt     <= w_tmo_cnt_nxt;
    end
  end

  // The request is masked by reset so a reset cycle never starts a bus transfer.
  assign imem_req    = (r_state == S_FETCH) && !reset;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus_4   = w_pc_plus_4;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign flush       = r_flush;
  assign fetch_err   = r_fetch_err;

endmodule
